// File: rtl/const_encoder.sv
// ---------------------------------------------------------------------------
// const_encoder
//
// Narrows an 8-bit operand to a 6-bit immediate field, either zero-extended
// (CS=0) or sign-extended (CS=1). Values that do not fit are saturated
// (SAT_EN=1) or truncated (SAT_EN=0) and flagged with ovf. Encoded results
// pass through a 2-entry FIFO with valid/ready handshakes on both sides.
//
// Parameters
//   SAT_EN      1 = saturate out-of-range values, 0 = truncate to value[5:0]
//
// Ports
//   clk         single clock, rising edge
//   reset       synchronous active-high reset
//   in_valid    upstream offers value/CS
//   in_ready    FIFO has room (count < 2)
//   value       8-bit operand
//   CS          0 = unsigned field, 1 = signed field
//   out_valid   head entry available
//   out_ready   downstream accepts head entry
//   IM          6-bit immediate of head entry
//   CS_out      CS captured with head entry
//   ovf         head entry did not fit the field
//   reject_cnt  saturating count of accepted non-fitting values
// ---------------------------------------------------------------------------
module const_encoder #(
    parameter int SAT_EN = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] value,
    input  logic       CS,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [5:0] IM,
    output logic       CS_out,
    output logic       ovf,
    output logic [7:0] reject_cnt
);

    // Entry layout: {IM[5:0], CS, ovf}
    logic [7:0] mem_q [2];
    logic [7:0] mem_d [2];
    logic       wrPtr_q, wrPtr_d;
    logic       rdPtr_q, rdPtr_d;
    logic [1:0] count_q, count_d;
    logic [7:0] rejectCnt_q, rejectCnt_d;

    logic       fits;
    logic [5:0] encIm;
    logic       push;
    logic       pop;
    logic [7:0] headEntry;

    // Fit check and encoding of the incoming operand. A signed field holds
    // the value only when bits 7..5 all equal the sign; an unsigned field
    // only when bits 7..6 are clear. Saturation picks the nearest
    // representable endpoint of the field.
    always_comb begin
        fits  = 1'b0;
        encIm = value[5:0];
        if (CS) begin
            fits = (value[7] == value[6]) && (value[6] == value[5]);
        end else begin
            fits = (value[7:6] == 2'b00);
        end
        if (!fits && (SAT_EN != 0)) begin
            if (!CS) begin
                encIm = 6'h3F;
            end else if (value[7]) begin
                encIm = 6'h20;
            end else begin
                encIm = 6'h1F;
            end
        end
    end

    assign in_ready  = (count_q < 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign headEntry  = mem_q[rdPtr_q];
    assign IM         = headEntry[7:2];
    assign CS_out     = headEntry[1];
    assign ovf        = headEntry[0];
    assign reject_cnt = rejectCnt_q;

    // Next-state for FIFO storage, pointers, occupancy and the reject
    // counter. A push at full and a pop at empty are already masked by the
    // ready/valid terms, so count can never wrap.
    always_comb begin
        mem_d       = mem_q;
        wrPtr_d     = wrPtr_q;
        rdPtr_d     = rdPtr_q;
        count_d     = count_q;
        rejectCnt_d = rejectCnt_q;

        if (push) begin
            mem_d[wrPtr_q] = {encIm, CS, ~fits};
            wrPtr_d        = ~wrPtr_q;
            if (!fits && (rejectCnt_q != 8'hFF)) begin
                rejectCnt_d = rejectCnt_q + 8'd1;
            end
        end
        if (pop) begin
            rdPtr_d = ~rdPtr_q;
        end
        if (push && !pop) begin
            count_d = count_q + 2'd1;
        end else if (pop && !push) begin
            count_d = count_q - 2'd1;
        end
    end

    // State registers. Storage is cleared on reset so the head outputs read
    // as zero and nothing queued before reset can reappear afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q[0]    <= 8'h00;
            mem_q[1]    <= 8'h00;
            wrPtr_q     <= 1'b0;
            rdPtr_q     <= 1'b0;
            count_q     <= 2'd0;
            rejectCnt_q <= 8'h00;
        end else begin
            mem_q[0]    <= mem_d[0];
            mem_q[1]    <= mem_d[1];
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            count_q     <= count_d;
            rejectCnt_q <= rejectCnt_d;
        end
    end

endmodule

// File: doc/const_encoder.md
CONST_ENCODER -- requirements
Module: const_encoder

Interface
REQ-001 SHALL have parameter: SAT_EN, default 1, 1 = saturate out-of-range values, 0 = truncate to value[5:0].
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: in_valid  input  1  upstream offers value.
REQ-005 SHALL have port: in_ready  output  1  block can accept value this cycle.
REQ-006 SHALL have port: value  input  8  operand to narrow to 6-bit immediate field.
REQ-007 SHALL have port: CS  input  1  0 = unsigned (zero-extend) field, 1 = signed (sign-extend) field; sampled with value.
REQ-008 SHALL have port: out_valid  output  1  head entry available.
REQ-009 SHALL have port: out_ready  input  1  downstream accepts head entry.
REQ-010 SHALL have port: IM  output  6  encoded immediate of head entry.
REQ-011 SHALL have port: CS_out  output  1  CS captured with head entry.
REQ-012 SHALL have port: ovf  output  1  head entry did not fit the field.
REQ-013 SHALL have port: reject_cnt  output  8  count of accepted values that did not fit, saturating.

Function
REQ-014 SHALL hold a 2-entry FIFO of {IM, CS_out, ovf} with occupancy count 0..2.
REQ-015 in_ready SHALL be 1 when count < 2, else 0; combinational from count only, never from out_ready.
REQ-016 Accept (push) SHALL occur on a clock edge where in_valid=1 and in_ready=1.
REQ-017 Pop SHALL occur on a clock edge where out_valid=1 and out_ready=1.
REQ-018 out_valid SHALL be 1 when count != 0; IM/CS_out/ovf SHALL show the oldest entry; contents are don't-care when out_valid=0.
REQ-019 Latency: a value accepted at edge N SHALL be visible at the outputs after edge N when the FIFO was empty; there is no combinational bypass.
REQ-020 Fit rule, CS=0: value fits if and only if value[7:6]=2'b00.
REQ-021 Fit rule, CS=1: value fits if and only if value[7]=value[6]=value[5].
REQ-022 A fitting value SHALL be encoded as IM=value[5:0], ovf=0.
REQ-023 If a value does not fit and SAT_EN=1, CS=0: IM=6'h3F; CS=1 with value[7]=0: IM=6'h1F; CS=1 with value[7]=1: IM=6'h20. ovf=1 in all three cases.
REQ-024 If a value does not fit and SAT_EN=0: IM=value[5:0], ovf=1.
REQ-025 Round-trip property: for ovf=0, zero-extending IM (CS_out=0) or sign-extending IM (CS_out=1) to 8 bits SHALL equal the original value.
REQ-026 reject_cnt SHALL increment by 1 on each accepted non-fitting value and hold at 8'hFF once it reaches 8'hFF.
REQ-027 Simultaneous push and pop at count=1: count stays 1 and the new entry becomes head.
REQ-028 Simultaneous push and pop at count=2: push is impossible (in_ready=0); pop only, count becomes 1.
REQ-029 Pop at count=0 and push at count=2 SHALL have no effect; count never wraps.
REQ-030 Entry order SHALL be strictly FIFO; no entry is dropped or duplicated.

Reset
REQ-031 While reset=1 at a clock edge: count=0, out_valid=0, in_ready=1 after the edge, reject_cnt=0, FIFO pointers=0; in_valid/out_ready are ignored that cycle.
REQ-032 Reset asserted mid-operation SHALL discard all queued entries; no entry accepted before reset is output after it.
REQ-033 IM, CS_out, ovf SHALL reset to 0.

Verification
REQ-034 Scenario: CS=0, value=8'h2A, out_ready=1 -> next cycle out_valid=1, IM=6'h2A, ovf=0, reject_cnt=0.
REQ-035 Scenario: CS=1, values 8'hE5, 8'h45, 8'h9C (SAT_EN=1) -> IM=6'h25 ovf=0; IM=6'h1F ovf=1; IM=6'h20 ovf=1; reject_cnt=2.
REQ-036 Scenario: out_ready=0, three back-to-back in_valid with 8'h01, 8'h02, 8'h03 -> first two accepted, in_ready=0 on the third; after out_ready=1, outputs 01, 02, then 03 in order.
REQ-037 Scenario: count=1, push 8'h07 with a simultaneous pop -> count stays 1, IM=6'h07 next cycle.
REQ-038 Scenario: 260 non-fitting values (CS=0, value=8'hC0) -> reject_cnt=8'hFF, no wrap.
REQ-039 Scenario: count=2, then reset pulse of 1 cycle -> out_valid=0, in_ready=1, reject_cnt=0; a next push of 8'h05 appears alone at the outputs.
